// File: rtl/pid_sched_if.sv
// pid_sched_if: heading-sample and wheel-speed bundle for the heading PID block.
//   master (heading source / test driver):
//     out moving, hdng_vld, dsrd_hdng[11:0], actl_hdng[11:0], frwrd_spd[10:0]
//     in  lft_spd[11:0], rght_spd[11:0], busy, pid_vld
//   slave (pid_sched): the same signals with the directions reversed.
interface pid_sched_if;
  logic               moving;
  logic               hdng_vld;
  logic signed [11:0] dsrd_hdng;
  logic signed [11:0] actl_hdng;
  logic        [10:0] frwrd_spd;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               busy;
  logic               pid_vld;

  modport master (
    output moving, hdng_vld, dsrd_hdng, actl_hdng, frwrd_spd,
    input  lft_spd, rght_spd, busy, pid_vld
  );

  modport slave (
    input  moving, hdng_vld, dsrd_hdng, actl_hdng, frwrd_spd,
    output lft_spd, rght_spd, busy, pid_vld
  );
endinterface

// File: rtl/pid_sched.sv
// pid_sched: sequenced heading PID controller with one shared 10x5 signed
// multiplier. A heading strobe in IDLE walks ERR -> MUL_P -> MUL_D -> SUM and
// the summed, scaled correction is added to / subtracted from the forward
// speed to give registered left/right wheel speeds.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous active-low reset
//   bus    pid_sched_if.slave: moving, hdng_vld, dsrd_hdng, actl_hdng,
//          frwrd_spd in; lft_spd, rght_spd, busy, pid_vld out
module pid_sched #(
  parameter logic signed [4:0] P_COEFF = 5'sh03,
  parameter logic signed [4:0] D_COEFF = 5'sh0E
) (
  input  logic        clk,
  input  logic        rst_n,
  pid_sched_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ERR, MUL_P, MUL_D, SUM} state_t;

  state_t state_q, state_d;

  logic               busy_q, busy_d;
  logic               pid_vld_q, pid_vld_d;
  // prev_err_q is written with err_sat in ERR, so during MUL_P it also
  // serves as the registered err_sat operand.
  logic signed [9:0]  prev_err_q, prev_err_d;
  logic signed [7:0]  diff_q, diff_d;
  logic signed [15:0] integ_q, integ_d;
  logic signed [13:0] p_term_q, p_term_d;
  logic signed [12:0] d_term_q, d_term_d;
  logic signed [11:0] lft_q, lft_d;
  logic signed [11:0] rght_q, rght_d;

  logic signed [11:0] err_c;
  logic signed [9:0]  err_sat_c;
  logic signed [10:0] err_ext_c, prev_ext_c;
  logic signed [7:0]  diff_c;
  logic signed [15:0] integ_add_c, integ_sum_c;
  logic               integ_ovf_c;
  logic signed [9:0]  mul_a_c;
  logic signed [4:0]  mul_b_c;
  logic signed [14:0] prod_c;
  logic               prod_unused;
  logic signed [11:0] i_term_c;
  logic signed [13:0] pid_sum_c;
  logic signed [10:0] pid_c;
  logic signed [12:0] fwd_c, pid_ext_c, lft_sum_c, rght_sum_c;

  function automatic logic signed [9:0] sat10(input logic signed [11:0] v);
    if (v > 12'sd511)       return 10'sd511;
    else if (v < -12'sd512) return -10'sd512;
    else                    return v[9:0];
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [10:0] v);
    if (v > 11'sd127)       return 8'sd127;
    else if (v < -11'sd128) return -8'sd128;
    else                    return v[7:0];
  endfunction

  function automatic logic signed [11:0] sat12(input logic signed [12:0] v);
    if (v > 13'sd2047)       return 12'sd2047;
    else if (v < -13'sd2048) return -12'sd2048;
    else                     return v[11:0];
  endfunction

  // ---- FSM next state: only IDLE waits; strobes elsewhere are dropped ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.hdng_vld) state_d = ERR;
      ERR:     state_d = MUL_P;
      MUL_P:   state_d = MUL_D;
      MUL_D:   state_d = SUM;
      SUM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- Error, derivative and integrator arithmetic ----
  always_comb begin
    err_c       = bus.actl_hdng - bus.dsrd_hdng;
    err_sat_c   = sat10(err_c);
    err_ext_c   = {err_sat_c[9], err_sat_c};
    prev_ext_c  = {prev_err_q[9], prev_err_q};
    diff_c      = sat8(err_ext_c - prev_ext_c);
    integ_add_c = {{6{err_sat_c[9]}}, err_sat_c};
    integ_sum_c = integ_q + integ_add_c;
    // Same-sign operands with a flipped result sign: keep the old value.
    integ_ovf_c = (integ_q[15] == integ_add_c[15]) &&
                  (integ_sum_c[15] != integ_q[15]);
  end

  // ---- Shared multiplier: operands selected by state ----
  always_comb begin
    if (state_q == MUL_D) begin
      mul_a_c = {{2{diff_q[7]}}, diff_q};
      mul_b_c = D_COEFF;
    end else begin
      mul_a_c = prev_err_q;
      mul_b_c = P_COEFF;
    end
    prod_c      = $signed({{5{mul_a_c[9]}}, mul_a_c}) *
                  $signed({{10{mul_b_c[4]}}, mul_b_c});
    prod_unused = prod_c[14];
  end

  // ---- Term sum, scaling and speed mix ----
  always_comb begin
    i_term_c   = integ_q[15:4];
    pid_sum_c  = p_term_q + {{2{i_term_c[11]}}, i_term_c} +
                 {d_term_q[12], d_term_q};
    // Dropping the low three bits of the signed sum is the >>> 3.
    pid_c      = pid_sum_c[13:3];
    fwd_c      = {2'b00, bus.frwrd_spd};
    pid_ext_c  = {{2{pid_c[10]}}, pid_c};
    lft_sum_c  = fwd_c + pid_ext_c;
    rght_sum_c = fwd_c - pid_ext_c;
  end

  // ---- Register next-state values ----
  always_comb begin
    busy_d     = (state_d != IDLE);
    pid_vld_d  = (state_d == SUM);
    prev_err_d = prev_err_q;
    diff_d     = diff_q;
    integ_d    = integ_q;
    p_term_d   = p_term_q;
    d_term_d   = d_term_q;
    lft_d      = lft_q;
    rght_d     = rght_q;
    case (state_q)
      ERR: begin
        prev_err_d = err_sat_c;
        diff_d     = diff_c;
        if (!integ_ovf_c) integ_d = integ_sum_c;
      end
      MUL_P: p_term_d = prod_c[13:0];
      MUL_D: d_term_d = prod_c[12:0];
      SUM: begin
        if (bus.moving) begin
          lft_d  = sat12(lft_sum_c);
          rght_d = sat12(rght_sum_c);
        end else begin
          lft_d  = '0;
          rght_d = '0;
        end
      end
      default: ;
    endcase
    // A stopped robot must not wind up the integrator, whatever the state.
    if (!bus.moving) integ_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      pid_vld_q  <= 1'b0;
      prev_err_q <= '0;
      diff_q     <= '0;
      integ_q    <= '0;
      p_term_q   <= '0;
      d_term_q   <= '0;
      lft_q      <= '0;
      rght_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      pid_vld_q  <= pid_vld_d;
      prev_err_q <= prev_err_d;
      diff_q     <= diff_d;
      integ_q    <= integ_d;
      p_term_q   <= p_term_d;
      d_term_q   <= d_term_d;
      lft_q      <= lft_d;
      rght_q     <= rght_d;
    end
  end

  assign bus.lft_spd  = lft_q;
  assign bus.rght_spd = rght_q;
  assign bus.busy     = busy_q;
  assign bus.pid_vld  = pid_vld_q;

endmodule
